led_pattern_gen: RTL and testbench

Multi-channel LED driver for board status indication, generalising the fixed 1 Hz single-LED blinker into NUM_CH independently configured channels. A shared millisecond-class prescaler drives per-channel phase counters. Each channel is set through a single-cycle write port to off, on, blink, or breathe mode, with programmable period and duty. It sits between the top-level clock/reset and the board LED pins, and out of reset blinks every channel without any configuration.

---
 rtl/led_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler, per-channel OFF/ON/BLINK/BREATHE.
// Define LED_BREATHE_EN to build the breathe PWM; otherwise mode 3 behaves as BLINK.

module led_ch #(
    parameter int CNT_W      = 16,
    parameter int PWM_W      = 8,
    parameter int RST_PERIOD = 1000,
    parameter int RST_DUTY   = 500
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tick,
    input  logic             sync_restart,
    input  logic             load,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
`ifdef LED_BREATHE_EN
    input  logic [PWM_W-1:0] pwm_cnt,
`endif
    output logic             on
);
    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_t;

    mode_t            mode;
    logic [CNT_W-1:0] period, duty, phase, eff_period;
    logic             wrap, blink_on;

    assign eff_period = (period == '0) ? CNT_W'(1) : period;
    assign wrap       = tick && (phase == eff_period - CNT_W'(1));
    assign blink_on   = (phase < duty);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode   <= M_BLINK;
            period <= CNT_W'(RST_PERIOD);
            duty   <= CNT_W'(RST_DUTY);
            phase  <= '0;
        end else begin
            if (load) begin
                mode   <= mode_t'(cfg_mode);
                period <= cfg_period;
                duty   <= cfg_duty;
            end
            // A clear beats a coincident tick.
            if (load || sync_restart) phase <= '0;
            else if (wrap)            phase <= '0;
            else if (tick)            phase <= phase + CNT_W'(1);
        end
    end

`ifdef LED_BREATHE_EN
    localparam logic [PWM_W-1:0] LVL_TOP = '1;

    logic [PWM_W-1:0] level;
    logic             dir_up;

    // Level walks one step per phase wrap, bouncing between 0 and full scale.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level  <= '0;
            dir_up <= 1'b1;
        end else if (load || sync_restart) begin
            level  <= '0;
            dir_up <= 1'b1;
        end else if (wrap) begin
            if (dir_up) begin
                level <= level + PWM_W'(1);
                if (level == LVL_TOP - PWM_W'(1)) dir_up <= 1'b0;
            end else begin
                level <= level - PWM_W'(1);
                if (level == PWM_W'(1)) dir_up <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        on = 1'b0;
        case (mode)
            M_OFF:     on = 1'b0;
            M_ON:      on = 1'b1;
            M_BLINK:   on = blink_on;
`ifdef LED_BREATHE_EN
            M_BREATHE: on = (pwm_cnt < level);
`else
            M_BREATHE: on = blink_on;
`endif
            default:   on = 1'b0;
        endcase
    end
endmodule

module led_pattern_gen #(
    parameter int NUM_CH          = 4,
    parameter int CH_W            = 2,
    parameter int PRESCALE        = 50000,
    parameter int CNT_W           = 16,
    parameter int PWM_W           = 8,
    parameter int RST_PERIOD      = 1000,
    parameter int RST_DUTY        = 500,
    parameter int LED_ACTIVE_HIGH = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic              sync_restart,
    output logic              tick,
    output logic [NUM_CH-1:0] led
);
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic            INV     = (LED_ACTIVE_HIGH == 0);

    logic [PS_W-1:0]   ps_cnt;
    logic [NUM_CH-1:0] on;

    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                ps_cnt <= '0;
        else if (sync_restart || tick) ps_cnt <= '0;
        else                           ps_cnt <= ps_cnt + PS_W'(1);
    end

`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pwm_cnt <= '0;
        else            pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
`endif

    // Channel indices never reach NUM_CH, so out-of-range writes match nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_ch #(
            .CNT_W     (CNT_W),
            .PWM_W     (PWM_W),
            .RST_PERIOD(RST_PERIOD),
            .RST_DUTY  (RST_DUTY)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .tick        (tick),
            .sync_restart(sync_restart),
            .load        (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_mode    (cfg_mode),
            .cfg_period  (cfg_period),
            .cfg_duty    (cfg_duty),
`ifdef LED_BREATHE_EN
            .pwm_cnt     (pwm_cnt),
`endif
            .on          (on[i])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) led <= {NUM_CH{INV}};
        else            led <= on ^ {NUM_CH{INV}};
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a tick/wrap-count reference model.
// Honours LED_BREATHE_EN the same way the design does.

module tb_led_pattern_gen;
    localparam int NCH  = 3;
    localparam int P    = 4;
    localparam int RP   = 10;
    localparam int RD   = 5;
    localparam int LTOP = 15;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_duty = '0;
    logic        sync_restart = 1'b0;
    logic        tick;
    logic [2:0]  led;

    int errors = 0;
    int checks = 0;

    int       m_ps, m_pwm;
    int       m_mode[NCH], m_per[NCH], m_duty[NCH], m_phase[NCH], m_wraps[NCH];
    logic [2:0] m_led;

    always #5 sys_clk = ~sys_clk;

    led_pattern_gen #(
        .NUM_CH(NCH), .CH_W(2), .PRESCALE(P), .CNT_W(16), .PWM_W(4),
        .RST_PERIOD(RP), .RST_DUTY(RD), .LED_ACTIVE_HIGH(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .sync_restart(sync_restart), .tick(tick), .led(led)
    );

    // Breathe level as a triangle wave of the number of phase wraps since the last clear.
    function automatic int tri_lvl(int w);
        int m = w % (2 * LTOP);
        return (m <= LTOP) ? m : 2 * LTOP - m;
    endfunction

    function automatic logic m_on(int c);
        case (m_mode[c])
            0: return 1'b0;
            1: return 1'b1;
            2: return m_phase[c] < m_duty[c];
`ifdef LED_BREATHE_EN
            default: return m_pwm < tri_lvl(m_wraps[c]);
`else
            default: return m_phase[c] < m_duty[c];
`endif
        endcase
    endfunction

    function automatic void m_reset();
        m_ps = 0; m_pwm = 0; m_led = '0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 2; m_per[c] = RP; m_duty[c] = RD; m_phase[c] = 0; m_wraps[c] = 0;
        end
    endfunction

    function automatic void m_edge();
        logic [2:0] nl;
        bit tk = (m_ps == P - 1);
        int eff;
        for (int c = 0; c < NCH; c++) nl[c] = m_on(c);
        m_ps = sync_restart ? 0 : (m_ps + 1) % P;
        for (int c = 0; c < NCH; c++) begin
            eff = (m_per[c] == 0) ? 1 : m_per[c];
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c] = cfg_mode; m_per[c] = cfg_period; m_duty[c] = cfg_duty;
                m_phase[c] = 0; m_wraps[c] = 0;
            end else if (sync_restart) begin
                m_phase[c] = 0; m_wraps[c] = 0;
            end else if (tk) begin
                if (m_phase[c] == eff - 1) begin
                    m_phase[c] = 0; m_wraps[c]++;
                end else m_phase[c]++;
            end
        end
        m_pwm = (m_pwm + 1) % 16;
        m_led = nl;
    endfunction

    task automatic cycle();
        @(posedge sys_clk);
        m_edge();
        #1;
    endtask

    task automatic write_cfg(input int ch, input int mode, input int per, input int duty);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
        cfg_period = 16'(per); cfg_duty = 16'(duty);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        int high0 = 0;
        sys_rst_n = 1'b0;
        m_reset();
        #3;
        checks++;
        if (led !== 3'b000 || tick !== 1'b0) begin
            errors++; $display("FAIL reset_state: led=%b tick=%b want led=000 tick=0", led, tick);
        end
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            cycle();
            if (k < 40 && led[0]) high0++;
            checks++;
            if (led !== m_led || tick !== (m_ps == P - 1)) begin
                errors++;
                $display("FAIL reset_blink cyc%0d: led=%b tick=%b want led=%b tick=%0d", k, led, tick, m_led, m_ps == P - 1);
            end
        end
        checks++;
        if (high0 != 20) begin
            errors++; $display("FAIL reset_duty: led0 high %0d of 40 cycles want 20", high0);
        end
    endtask

    task automatic test_on();
        write_cfg(1, 1, 10, 5);
        for (int k = 0; k < 30; k++) begin
            cycle();
            checks++;
            if (led !== m_led || (led[1] !== 1'b1)) begin
                errors++; $display("FAIL on_mode cyc%0d: led=%b want %b (led1=1)", k, led, m_led);
            end
        end
    endtask

    task automatic test_blink_edges();
        write_cfg(0, 2, 3, 3);
        cycle();
        for (int k = 0; k < 24; k++) begin
            cycle();
            checks++;
            if (led !== m_led || led[0] !== 1'b1) begin
                errors++; $display("FAIL blink_duty_full cyc%0d: led=%b want %b", k, led, m_led);
            end
        end
        write_cfg(0, 2, 3, 0);
        cycle();
        for (int k = 0; k < 24; k++) begin
            cycle();
            checks++;
            if (led !== m_led || led[0] !== 1'b0) begin
                errors++; $display("FAIL blink_duty_zero cyc%0d: led=%b want %b", k, led, m_led);
            end
        end
    endtask

    task automatic test_bad_ch();
        write_cfg(3, 0, 1, 0);
        for (int k = 0; k < 40; k++) begin
            cycle();
            checks++;
            if (led !== m_led || tick !== (m_ps == P - 1)) begin
                errors++; $display("FAIL bad_ch cyc%0d: led=%b tick=%b want led=%b", k, led, tick, m_led);
            end
        end
    endtask

    task automatic test_sync_restart();
        int n = 0;
        write_cfg(0, 2, RP, RD);
        write_cfg(1, 2, RP, RD);
        repeat (7) cycle();
        while (tick !== 1'b1 && n < 8) begin cycle(); n++; end
        checks++;
        if (tick !== 1'b1) begin
            errors++; $display("FAIL sync_wait: tick=%b want 1 within 8 cycles", tick);
        end
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        repeat (3) cycle();
        checks++;
        if (tick !== 1'b1) begin
            errors++; $display("FAIL sync_tick_gap: tick=%b want 1 four cycles after restart", tick);
        end
        for (int k = 0; k < 60; k++) begin
            cycle();
            checks++;
            if (led !== m_led || tick !== (m_ps == P - 1)) begin
                errors++; $display("FAIL sync_restart cyc%0d: led=%b tick=%b want led=%b", k, led, tick, m_led);
            end
        end
    endtask

    task automatic test_breathe();
        write_cfg(2, 3, 1, 0);
        for (int k = 0; k < 260; k++) begin
            cycle();
            checks++;
            if (led !== m_led) begin
                errors++; $display("FAIL breathe cyc%0d: led=%b want %b", k, led, m_led);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1; cfg_ch = 2'($urandom_range(0, 3)); cfg_mode = 2'($urandom_range(0, 3));
                cfg_period = 16'($urandom_range(0, 6)); cfg_duty = 16'($urandom_range(0, 7));
            end
            sync_restart = ($urandom_range(0, 29) == 0);
            cycle();
            cfg_we = 1'b0; sync_restart = 1'b0;
            checks++;
            if (led !== m_led || tick !== (m_ps == P - 1)) begin
                errors++; $display("FAIL random cyc%0d: led=%b tick=%b want led=%b tick=%0d", k, led, tick, m_led, m_ps == P - 1);
            end
        end
    endtask

    task automatic test_async_reset();
        write_cfg(1, 1, 5, 2);
        repeat (3) cycle();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 3'b000 || tick !== 1'b0) begin
            errors++; $display("FAIL async_reset: led=%b tick=%b want led=000 tick=0", led, tick);
        end
        m_reset();
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        for (int k = 0; k < 45; k++) begin
            cycle();
            checks++;
            if (led !== m_led || tick !== (m_ps == P - 1)) begin
                errors++; $display("FAIL post_reset cyc%0d: led=%b want %b", k, led, m_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_on();
        test_blink_edges();
        test_bad_ch();
        test_sync_restart();
        test_breathe();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
